// File: rtl/cacheline_burst_adapter.sv
// cacheline_burst_adapter: one cache-line read/write <-> fixed-length
// burst of BUS_W-bit beats on the memory port.
module cacheline_burst_adapter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int BUS_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ufp_addr,
  input  logic              ufp_read,
  input  logic              ufp_write,
  input  logic [LINE_W-1:0] ufp_wdata,
  output logic [LINE_W-1:0] ufp_rdata,
  output logic              ufp_resp,
  output logic              ufp_err,
  output logic [ADDR_W-1:0] dfp_addr,
  output logic              dfp_read,
  output logic              dfp_write,
  output logic [BUS_W-1:0]  dfp_wdata,
  input  logic              dfp_ready,
  input  logic [ADDR_W-1:0] dfp_raddr,
  input  logic [BUS_W-1:0]  dfp_rdata,
  input  logic              dfp_rvalid
);

  localparam int BEATS = LINE_W / BUS_W;
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK =
    ADDR_W'((64'd1 << OFF_W) - 64'd1);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_BURST, WR_BURST, RESP
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wbuf_q;
  logic [LINE_W-1:0] rbuf_q;
  logic              err_q;

  logic start_wr, start_rd;
  logic rd_beat, wr_beat;

  logic [ADDR_W-1:0] aligned;
  assign aligned = ufp_addr & ~OFF_MASK;

  assign ufp_rdata = rbuf_q;
  assign dfp_addr  = addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_wr  = 1'b0;
    start_rd  = 1'b0;
    rd_beat   = 1'b0;
    wr_beat   = 1'b0;
    ufp_resp  = 1'b0;
    ufp_err   = 1'b0;
    dfp_read  = 1'b0;
    dfp_write = 1'b0;
    dfp_wdata = '0;
    unique case (state_q)
      IDLE: begin
        // write wins when both requests are up
        if (ufp_write) begin
          start_wr = 1'b1;
          state_d  = WR_BURST;
        end else if (ufp_read) begin
          start_rd = 1'b1;
          state_d  = RD_REQ;
        end
      end
      RD_REQ: begin
        dfp_read = 1'b1;
        if (dfp_ready) state_d = RD_BURST;
      end
      RD_BURST: begin
        if (dfp_rvalid) begin
          rd_beat = 1'b1;
          if (cnt_q == LAST) state_d = RESP;
        end
      end
      WR_BURST: begin
        dfp_write = 1'b1;
        dfp_wdata = wbuf_q[int'(cnt_q)*BUS_W +: BUS_W];
        if (dfp_ready) begin
          wr_beat = 1'b1;
          if (cnt_q == LAST) state_d = RESP;
        end
      end
      RESP: begin
        ufp_resp = 1'b1;
        ufp_err  = err_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      addr_q <= '0;
      wbuf_q <= '0;
      rbuf_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (start_wr) begin
        addr_q <= aligned;
        wbuf_q <= ufp_wdata;
        cnt_q  <= '0;
        err_q  <= 1'b0;
      end
      if (start_rd) begin
        addr_q <= aligned;
        cnt_q  <= '0;
        err_q  <= 1'b0;
      end
      if (rd_beat) begin
        rbuf_q[int'(cnt_q)*BUS_W +: BUS_W] <= dfp_rdata;
        cnt_q <= cnt_q + 1'b1;
        // any beat tagged with a foreign line poisons the response
        if (dfp_raddr != addr_q) err_q <= 1'b1;
      end
      if (wr_beat) cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// tb_cacheline_burst_adapter: random + directed bench, per-cycle plan
// of stimulus and expected outputs built from the burst rules.
module tb_cacheline_burst_adapter;

  localparam int AW  = 32;
  localparam int LW  = 256;
  localparam int BW  = 64;
  localparam int NB  = LW / BW;
  localparam int LW2 = 512;
  localparam int BW2 = 128;
  localparam int PL  = 64;

  localparam logic [LW-1:0] T1_LINE = {
    64'h4444_4444_DDDD_0003, 64'h3333_3333_CCCC_0002,
    64'h2222_2222_BBBB_0001, 64'h1111_1111_AAAA_0000};
  localparam logic [LW-1:0] T3_LINE = {
    64'h4040_4040_4040_4040, 64'h3030_3030_3030_3030,
    64'h2020_2020_2020_2020, 64'h1111_1111_FFEE_DDCC};

  logic clk = 1'b0;
  logic rst_n, rst2_n;
  always #5 clk = ~clk;

  logic [AW-1:0] ufp_addr, dfp_addr, dfp_raddr;
  logic          ufp_read, ufp_write, ufp_resp, ufp_err;
  logic [LW-1:0] ufp_wdata, ufp_rdata;
  logic          dfp_read, dfp_write, dfp_ready, dfp_rvalid;
  logic [BW-1:0] dfp_wdata, dfp_rdata;

  cacheline_burst_adapter dut (
    .clk(clk), .rst_n(rst_n),
    .ufp_addr(ufp_addr), .ufp_read(ufp_read),
    .ufp_write(ufp_write), .ufp_wdata(ufp_wdata),
    .ufp_rdata(ufp_rdata), .ufp_resp(ufp_resp),
    .ufp_err(ufp_err), .dfp_addr(dfp_addr),
    .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_ready(dfp_ready),
    .dfp_raddr(dfp_raddr), .dfp_rdata(dfp_rdata),
    .dfp_rvalid(dfp_rvalid)
  );

  logic [AW-1:0]  b_addr, b_dfp_addr, b_raddr;
  logic           b_read, b_write, b_resp, b_err;
  logic [LW2-1:0] b_wdata, b_rdata_o;
  logic           b_dfp_read, b_dfp_write, b_ready, b_rvalid;
  logic [BW2-1:0] b_dfp_wdata, b_rdata;

  cacheline_burst_adapter #(
    .ADDR_W(32), .LINE_W(LW2), .BUS_W(BW2)
  ) dut2 (
    .clk(clk), .rst_n(rst2_n),
    .ufp_addr(b_addr), .ufp_read(b_read),
    .ufp_write(b_write), .ufp_wdata(b_wdata),
    .ufp_rdata(b_rdata_o), .ufp_resp(b_resp),
    .ufp_err(b_err), .dfp_addr(b_dfp_addr),
    .dfp_read(b_dfp_read), .dfp_write(b_dfp_write),
    .dfp_wdata(b_dfp_wdata), .dfp_ready(b_ready),
    .dfp_raddr(b_raddr), .dfp_rdata(b_rdata),
    .dfp_rvalid(b_rvalid)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [511:0] act,
                     input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // per-cycle plan: stimulus and expected outputs
  logic          p_rd[PL], p_wr[PL], p_rdy[PL], p_rv[PL];
  logic [BW-1:0] p_rdat[PL];
  logic [AW-1:0] p_radr[PL], p_ua[PL];
  logic [LW-1:0] p_uw[PL];
  logic          e_drd[PL], e_dwr[PL], e_resp[PL];
  logic [BW-1:0] e_wdat[PL];
  logic [AW-1:0] e_addr;
  logic [LW-1:0] exp_rd, model_line;
  logic          e_err;
  int            plen, cyc, b2_cyc;
  bit            chk_on = 1'b0;

  logic [AW-1:0] cap_addr;
  int            n_rd_hi, resp_cyc;
  logic          resp_err;
  logic [BW-1:0] wq[$];

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int k = 0; k < LW / 32; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a,
                                          input int bytes);
    return a - (a % bytes);
  endfunction

  task automatic clear_plan();
    for (int i = 0; i < PL; i++) begin
      p_rd[i]   = 1'b0;
      p_wr[i]   = 1'b0;
      p_rdy[i]  = ($urandom_range(0, 1) == 1);
      p_rv[i]   = ($urandom_range(0, 3) == 0);
      p_rdat[i] = {$urandom, $urandom};
      p_radr[i] = $urandom;
      p_ua[i]   = $urandom;
      p_uw[i]   = rand_line();
      e_drd[i]  = 1'b0;
      e_dwr[i]  = 1'b0;
      e_resp[i] = 1'b0;
      e_wdat[i] = '0;
    end
  endtask

  task automatic plan_read(input logic [AW-1:0] a, input int s,
                           input int gap, input int bad,
                           input logic [LW-1:0] beats,
                           input bit use_beats);
    int c, g;
    logic [BW-1:0] d;
    clear_plan();
    e_addr = align(a, LW / 8);
    p_rd[0] = 1'b1;
    p_ua[0] = a;
    for (int i = 1; i <= s + 1; i++) begin
      p_rd[i]  = 1'b1;
      e_drd[i] = 1'b1;
      p_rdy[i] = (i == s + 1);
    end
    c = s + 2;
    for (int k = 0; k < NB; k++) begin
      g = (gap < 0) ? $urandom_range(0, 2) : gap;
      for (int j = 0; j < g; j++) begin
        p_rd[c] = 1'b1;
        p_rv[c] = 1'b0;
        c++;
      end
      d = use_beats ? beats[k*BW +: BW] : {$urandom, $urandom};
      exp_rd[k*BW +: BW] = d;
      p_rd[c]   = 1'b1;
      p_rv[c]   = 1'b1;
      p_rdat[c] = d;
      p_radr[c] = (k == bad) ? 32'hDEAD_0000 : e_addr;
      if (k == 2) b2_cyc = c;
      c++;
    end
    e_resp[c] = 1'b1;
    p_rd[c]   = 1'b1;
    c++;
    plen  = c + 1;
    e_err = (bad >= 0 && bad < NB);
  endtask

  task automatic plan_write(input logic [AW-1:0] a,
                            input logic [LW-1:0] line,
                            input bit both, input bit use_pat,
                            input logic [15:0] pat);
    int c, k;
    logic r;
    clear_plan();
    e_addr  = align(a, LW / 8);
    p_wr[0] = 1'b1;
    p_rd[0] = both;
    p_ua[0] = a;
    p_uw[0] = line;
    k = 0;
    c = 1;
    while (k < NB) begin
      p_wr[c]   = 1'b1;
      p_rd[c]   = both;
      e_dwr[c]  = 1'b1;
      e_wdat[c] = line[k*BW +: BW];
      if (use_pat) r = pat[c-1];
      else r = (c > 40) || ($urandom_range(0, 1) == 1);
      p_rdy[c] = r;
      if (r) k++;
      c++;
    end
    e_resp[c] = 1'b1;
    p_wr[c]   = 1'b1;
    p_rd[c]   = both;
    c++;
    plen   = c + 1;
    e_err  = 1'b0;
    exp_rd = model_line;
  endtask

  task automatic run_plan(input int upto);
    n_rd_hi  = 0;
    resp_cyc = -1;
    resp_err = 1'bx;
    wq.delete();
    for (int c = 0; c < upto; c++) begin
      @(posedge clk);
      #1;
      ufp_read   = p_rd[c];
      ufp_write  = p_wr[c];
      ufp_addr   = p_ua[c];
      ufp_wdata  = p_uw[c];
      dfp_ready  = p_rdy[c];
      dfp_rvalid = p_rv[c];
      dfp_rdata  = p_rdat[c];
      dfp_raddr  = p_radr[c];
      cyc    = c;
      chk_on = 1'b1;
      @(negedge clk);
      #1;
      chk_on = 1'b0;
    end
    if (upto == plen) model_line = exp_rd;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("dfp_read", dfp_read, e_drd[cyc]);
      chk("dfp_write", dfp_write, e_dwr[cyc]);
      chk("ufp_resp", ufp_resp, e_resp[cyc]);
      if (e_dwr[cyc]) chk("dfp_wdata", dfp_wdata, e_wdat[cyc]);
      if (e_drd[cyc] || e_dwr[cyc])
        chk("dfp_addr", dfp_addr, e_addr);
      if (e_resp[cyc]) begin
        chk("ufp_rdata", ufp_rdata, exp_rd);
        chk("ufp_err", ufp_err, e_err);
      end else begin
        chk("ufp_err_idle", ufp_err, 1'b0);
      end
      if (cyc == plen - 1) chk("ufp_rdata_hold", ufp_rdata, exp_rd);
      if (dfp_read || dfp_write) cap_addr = dfp_addr;
      if (dfp_read) n_rd_hi++;
      if (dfp_write && dfp_ready) wq.push_back(dfp_wdata);
      if (ufp_resp) begin
        resp_cyc = cyc;
        resp_err = ufp_err;
      end
    end
  end

  task automatic chk_zero(input string nm);
    chk({nm, "_resp"}, ufp_resp, 1'b0);
    chk({nm, "_err"}, ufp_err, 1'b0);
    chk({nm, "_dread"}, dfp_read, 1'b0);
    chk({nm, "_dwrite"}, dfp_write, 1'b0);
    chk({nm, "_wdata"}, dfp_wdata, '0);
    chk({nm, "_addr"}, dfp_addr, '0);
    chk({nm, "_rdata"}, ufp_rdata, '0);
  endtask

  task automatic d2_read(input logic [AW-1:0] a, input int rst_at);
    logic [AW-1:0]  al;
    logic [LW2-1:0] ln;
    logic [BW2-1:0] d;
    al = align(a, LW2 / 8);
    ln = '0;
    @(posedge clk);
    #1 b_read = 1'b1;
    b_addr = a;
    @(negedge clk);
    chk("d2_idle_dread", b_dfp_read, 1'b0);
    @(posedge clk);
    #1 b_ready = 1'b1;
    b_addr = $urandom;
    @(negedge clk);
    chk("d2_dread", b_dfp_read, 1'b1);
    chk("d2_addr", b_dfp_addr, al);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 b_ready = 1'b0;
      d = {$urandom, $urandom, $urandom, $urandom};
      ln[k*BW2 +: BW2] = d;
      b_rvalid = 1'b1;
      b_rdata  = d;
      b_raddr  = al;
      if (k == rst_at) begin
        @(negedge clk);
        #1 rst2_n = 1'b0;
        #1;
        chk("d2_rst_resp", b_resp, 1'b0);
        chk("d2_rst_dread", b_dfp_read, 1'b0);
        chk("d2_rst_addr", b_dfp_addr, '0);
        chk("d2_rst_rdata", b_rdata_o, '0);
        @(posedge clk);
        #1 b_read = 1'b0;
        @(posedge clk);
        #1 rst2_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
          @(posedge clk);
          #1 b_rdata = {$urandom, $urandom, $urandom, $urandom};
          @(negedge clk);
          chk("d2_post_rst_resp", b_resp, 1'b0);
          chk("d2_post_rst_rdata", b_rdata_o, '0);
        end
        b_rvalid = 1'b0;
        return;
      end
      @(negedge clk);
      chk("d2_no_early_resp", b_resp, 1'b0);
    end
    @(posedge clk);
    #1 b_rvalid = 1'b0;
    @(negedge clk);
    chk("d2_resp", b_resp, 1'b1);
    chk("d2_rdata", b_rdata_o, ln);
    chk("d2_err", b_err, 1'b0);
    @(posedge clk);
    #1 b_read = 1'b0;
    @(negedge clk);
    chk("d2_resp_pulse", b_resp, 1'b0);
    chk("d2_rdata_hold", b_rdata_o, ln);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    rst2_n = 1'b0;
    ufp_addr = '0; ufp_read = 1'b0; ufp_write = 1'b0;
    ufp_wdata = '0; dfp_ready = 1'b0; dfp_rvalid = 1'b0;
    dfp_rdata = '0; dfp_raddr = '0;
    b_addr = '0; b_read = 1'b0; b_write = 1'b0; b_wdata = '0;
    b_ready = 1'b0; b_rvalid = 1'b0; b_rdata = '0; b_raddr = '0;
    model_line = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    rst2_n = 1'b1;

    plan_read(32'h0000_1234, 0, 0, -1, T1_LINE, 1'b1);
    run_plan(plen);
    chk("t1_addr", cap_addr, 32'h0000_1220);
    chk("t1_read_cycles", n_rd_hi, 1);
    chk("t1_resp_cycle", resp_cyc, 6);
    chk("t1_line", ufp_rdata, T1_LINE);

    plan_read(32'h0000_1234, 4, 2, -1, T1_LINE, 1'b1);
    run_plan(plen);
    chk("t2_read_cycles", n_rd_hi, 5);
    chk("t2_resp_cycle", resp_cyc, 18);

    plan_write(32'h8000_0040, T3_LINE, 1'b0, 1'b1, 16'b10_1101);
    run_plan(plen);
    chk("t3_addr", cap_addr, 32'h8000_0040);
    chk("t3_beats", wq.size(), 4);
    if (wq.size() == 4) begin
      chk("t3_beat0", wq[0], 64'h1111_1111_FFEE_DDCC);
      chk("t3_beat3", wq[3], 64'h4040_4040_4040_4040);
    end
    chk("t3_resp_cycle", resp_cyc, 7);
    chk("t3_rdata_kept", ufp_rdata, T1_LINE);

    plan_write($urandom, rand_line(), 1'b1, 1'b0, '0);
    run_plan(plen);
    chk("t4_write_beats", wq.size(), NB);
    chk("t4_no_read", n_rd_hi, 0);
    plan_read($urandom, $urandom_range(0, 4), -1, -1, '0, 1'b0);
    run_plan(plen);

    plan_read(32'h0000_0100, $urandom_range(0, 4), -1, 2, '0, 1'b0);
    run_plan(plen);
    chk("t5_err_set", resp_err, 1'b1);
    plan_read(32'h0000_0100, $urandom_range(0, 4), -1, -1, '0, 1'b0);
    run_plan(plen);
    chk("t5_err_clear", resp_err, 1'b0);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1)
        plan_write($urandom, rand_line(),
                   $urandom_range(0, 1) == 1, 1'b0, '0);
      else
        plan_read($urandom, $urandom_range(0, 4), -1,
                  ($urandom_range(0, 4) == 0) ?
                    int'($urandom_range(0, 3)) : -1,
                  '0, 1'b0);
      run_plan(plen);
    end

    plan_read(32'h0000_2040, 1, 1, -1, '0, 1'b0);
    run_plan(b2_cyc + 1);
    #1 rst_n = 1'b0;
    #1 chk_zero("t6_rst");
    ufp_read = 1'b0;
    ufp_write = 1'b0;
    dfp_rvalid = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      #1 dfp_rdata = {$urandom, $urandom};
      dfp_raddr = $urandom;
      @(negedge clk);
      chk_zero("t6_stray");
    end
    dfp_rvalid = 1'b0;
    model_line = '0;
    plan_write($urandom, rand_line(), 1'b0, 1'b0, '0);
    run_plan(plen);
    chk("t6_write_rdata", ufp_rdata, '0);
    plan_read($urandom, 0, 0, -1, '0, 1'b0);
    run_plan(plen);

    d2_read(32'h0000_1234, -1);
    d2_read(32'h0000_5678, 2);
    d2_read(32'h0000_9ABC, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
